// File: rtl/fft_r22sdf_reorder.sv
// Natural-order reorder buffer behind the radix-2^2 SDF FFT: ping-pong 2 x N bank RAM,
// frames written by bin index and streamed out 0..N-1. Optional last_o via FFT_REORDER_LAST_EN.
module fft_r22sdf_reorder #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 25,
    localparam int N_LOG2    = $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  sync_i,
    input  logic [N_LOG2-1:0]     data_ctr_i,
    input  logic [DATA_WIDTH-1:0] data_re_i,
    input  logic [DATA_WIDTH-1:0] data_im_i,
    output logic                  valid_o,
    output logic [N_LOG2-1:0]     ctr_o,
    output logic [DATA_WIDTH-1:0] data_re_o,
    output logic [DATA_WIDTH-1:0] data_im_o
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic                  last_o
`endif
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int DEPTH  = 2 * N;
    localparam logic [N_LOG2-1:0] LAST_BIN = N_LOG2'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rd_state_t;

    // Write side
    logic [N_LOG2-1:0] wr_cnt_reg;
    logic              wr_bank_reg;
    logic              full_reg;
    logic              frame_done;

    // Read side
    rd_state_t         rd_state_reg;
    logic [N_LOG2-1:0] rd_cnt_reg;
    logic              rd_bank_reg;
    logic              rd_en;
    logic              rd_wrap;
    logic              take_frame;

    // Storage
    logic [WORD_W-1:0] ram [0:DEPTH-1];
    logic [WORD_W-1:0] rd_word_reg;
    logic [N_LOG2:0]   wr_addr;
    logic [N_LOG2:0]   rd_addr;

    assign frame_done = sync_i && (wr_cnt_reg == LAST_BIN);
    assign rd_en      = (rd_state_reg == S_STREAM);
    assign rd_wrap    = rd_en && (rd_cnt_reg == LAST_BIN);
    // A frame is handed to the reader either from IDLE or seamlessly at the end of a stream.
    assign take_frame = ((rd_state_reg == S_IDLE) && full_reg)
                      || (rd_wrap && (full_reg || frame_done));

    assign wr_addr = {wr_bank_reg, data_ctr_i};
    assign rd_addr = {rd_bank_reg, rd_cnt_reg};

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
        end else if (sync_i) begin
            if (frame_done) begin
                wr_cnt_reg  <= '0;
                wr_bank_reg <= ~wr_bank_reg;
            end else begin
                wr_cnt_reg  <= wr_cnt_reg + 1'b1;
            end
        end else begin
            // A gap mid-frame discards the partial frame; the bank is simply refilled.
            wr_cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
        end else if (take_frame) begin
            full_reg <= 1'b0;
        end else if (frame_done) begin
            full_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_state_reg <= S_IDLE;
            rd_cnt_reg   <= '0;
            rd_bank_reg  <= 1'b0;
            valid_o      <= 1'b0;
            ctr_o        <= '0;
        end else begin
            valid_o <= rd_en;
            if (rd_en) begin
                ctr_o <= rd_cnt_reg;
            end
            case (rd_state_reg)
                S_IDLE: begin
                    rd_cnt_reg <= '0;
                    if (full_reg) begin
                        // wr_bank has already flipped, so the completed bank is the other one.
                        rd_bank_reg  <= ~wr_bank_reg;
                        rd_state_reg <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (rd_cnt_reg == LAST_BIN) begin
                        rd_cnt_reg <= '0;
                        if (full_reg || frame_done) begin
                            rd_bank_reg <= ~rd_bank_reg;
                        end else begin
                            rd_state_reg <= S_IDLE;
                        end
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    rd_state_reg <= S_IDLE;
                    rd_cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef FFT_REORDER_LAST_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            last_o <= 1'b0;
        end else begin
            last_o <= rd_wrap;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (sync_i) begin
            ram[wr_addr] <= {data_re_i, data_im_i};
        end
    end

    // Registered read doubles as the output register, so data holds while valid_o is low.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_word_reg <= '0;
        end else if (rd_en) begin
            rd_word_reg <= ram[rd_addr];
        end
    end

    assign data_re_o = rd_word_reg[WORD_W-1:DATA_WIDTH];
    assign data_im_o = rd_word_reg[DATA_WIDTH-1:0];

endmodule
